// File: rtl/control_unit.sv
// Hardwired T-state sequencer for the single-bus datapath: fetch (T0..T2), decode (T3), 3-register ALU execute (T4..T5).
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes halt the controller with a sticky illegal flag.
module control_unit #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             pco,
    output logic             pci,
    output logic             incpc,
    output logic             mari,
    output logic             mdri,
    output logic             mdro,
    output logic             read,
    output logic             iri,
    output logic             yi,
    output logic             zi,
    output logic             zlowo,
    output logic [NREGS-1:0] rin,
    output logic [NREGS-1:0] rout,
    output logic [OPW-1:0]   alu_op,
    output logic             halted,
    output logic             illegal,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T1W  = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'd3);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'd4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'd5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'd6);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'd7);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'd8);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'd26);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'd27);

    state_t           state_r;
    state_t           state_next_s;
    logic [OPW-1:0]   op_s;
    logic [3:0]       ra_s;
    logic [3:0]       rb_s;
    logic [3:0]       rc_s;
    logic             unknown_s;
    logic             unused_ir_s;

    // One-hot register select; indices beyond the register file wrap around.
    function automatic logic [NREGS-1:0] reg_sel(input logic [3:0] idx);
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) begin
            v[i] = ((int'(idx) % NREGS) == i);
        end
        return v;
    endfunction

    assign op_s        = ir[31 -: OPW];
    assign ra_s        = ir[26:23];
    assign rb_s        = ir[22:19];
    assign rc_s        = ir[18:15];
    assign unused_ir_s = ^ir[14:0];
    assign state       = state_r;

    // State register; clear abandons any instruction in flight.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky trap flag, raised on the decode cycle that sees an unknown opcode.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            illegal_r <= 1'b0;
        end else if (state_r == S_T3 && unknown_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = (state_r == S_T3) && unknown_s;
`endif

    // Next-state and datapath enable decode from the current T-state and IR.
    always_comb begin
        state_next_s = state_r;
        unknown_s    = 1'b0;
        pco          = 1'b0;
        pci          = 1'b0;
        incpc        = 1'b0;
        mari         = 1'b0;
        mdri         = 1'b0;
        mdro         = 1'b0;
        read         = 1'b0;
        iri          = 1'b0;
        yi           = 1'b0;
        zi           = 1'b0;
        zlowo        = 1'b0;
        rin          = '0;
        rout         = '0;
        alu_op       = '0;
        halted       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    state_next_s = S_T0;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_T0: begin
                pco          = 1'b1;
                mari         = 1'b1;
                incpc        = 1'b1;
                zi           = 1'b1;
                state_next_s = S_T1;
            end
            S_T1, S_T1W: begin
                // PC is reloaded only on the first read cycle, never while waiting.
                pci   = (state_r == S_T1);
                zlowo = (state_r == S_T1);
                read  = 1'b1;
                mdri  = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_T2;
                end else begin
                    state_next_s = S_T1W;
                end
            end
            S_T2: begin
                mdro         = 1'b1;
                iri          = 1'b1;
                state_next_s = S_T3;
            end
            S_T3: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
                        rout         = reg_sel(rb_s);
                        yi           = 1'b1;
                        state_next_s = S_T4;
                    end
                    OP_NOP:  state_next_s = S_T0;
                    OP_HALT: state_next_s = S_HALT;
                    default: begin
                        unknown_s = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                        state_next_s = S_HALT;
`else
                        state_next_s = S_T0;
`endif
                    end
                endcase
            end
            S_T4: begin
                rout         = reg_sel(rc_s);
                zi           = 1'b1;
                alu_op       = op_s;
                state_next_s = S_T5;
            end
            S_T5: begin
                zlowo        = 1'b1;
                rin          = reg_sel(ra_s);
                state_next_s = S_T0;
            end
            S_HALT: begin
                halted       = 1'b1;
                state_next_s = S_HALT;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: per-cycle state and enable checks plus hand-written
// halt, unknown-opcode and mid-instruction reset sequences.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;
    logic        pco, pci, incpc, mari, mdri, mdro, read, iri, yi, zi, zlowo;
    logic [15:0] rin, rout;
    logic [4:0]  alu_op;
    logic        halted, illegal;
    logic [3:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    // ctrl bit order: {pco,pci,incpc,mari,mdri,mdro,read,iri,yi,zi,zlowo}
    localparam logic [10:0] PCO   = 11'b100_0000_0000;
    localparam logic [10:0] PCI   = 11'b010_0000_0000;
    localparam logic [10:0] INCPC = 11'b001_0000_0000;
    localparam logic [10:0] MARI  = 11'b000_1000_0000;
    localparam logic [10:0] MDRI  = 11'b000_0100_0000;
    localparam logic [10:0] MDRO  = 11'b000_0010_0000;
    localparam logic [10:0] READ  = 11'b000_0001_0000;
    localparam logic [10:0] IRI   = 11'b000_0000_1000;
    localparam logic [10:0] YI    = 11'b000_0000_0100;
    localparam logic [10:0] ZI    = 11'b000_0000_0010;
    localparam logic [10:0] ZLOWO = 11'b000_0000_0001;
    localparam logic [10:0] NONE  = 11'b000_0000_0000;

    localparam logic [10:0] C_T0 = PCO | MARI | INCPC | ZI;
    localparam logic [10:0] C_T1 = ZLOWO | PCI | READ | MDRI;
    localparam logic [10:0] C_TW = READ | MDRI;
    localparam logic [10:0] C_T2 = MDRO | IRI;

    localparam logic [31:0] IR_AND  = 32'h2891_8000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_ADD0 = 32'h1800_0000;
    localparam logic [31:0] IR_UNK  = 32'hF800_0000;

    typedef struct {
        logic        run;
        logic        mr;
        logic [31:0] ir;
        logic [3:0]  st;
        logic [10:0] ctrl;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  alu;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    control_unit dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .pco(pco), .pci(pci), .incpc(incpc), .mari(mari), .mdri(mdri), .mdro(mdro),
        .read(read), .iri(iri), .yi(yi), .zi(zi), .zlowo(zlowo),
        .rin(rin), .rout(rout), .alu_op(alu_op), .halted(halted), .illegal(illegal),
        .state(state)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic r, input logic m, input logic [31:0] i, input logic [3:0] s,
                                input logic [10:0] c, input logic [15:0] ro, input logic [15:0] ri,
                                input logic [4:0] a, input logic il);
        vec_t v;
        v.run = r; v.mr = m; v.ir = i; v.st = s; v.ctrl = c;
        v.rout = ro; v.rin = ri; v.alu = a; v.ill = il;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] st, input logic [10:0] c,
                             input logic [15:0] ro, input logic [15:0] ri, input logic [4:0] a,
                             input logic h, input logic il);
        chk({tag, ".state"},   32'(state), 32'(st));
        chk({tag, ".ctrl"},    32'({pco, pci, incpc, mari, mdri, mdro, read, iri, yi, zi, zlowo}), 32'(c));
        chk({tag, ".rout"},    32'(rout), 32'(ro));
        chk({tag, ".rin"},     32'(rin), 32'(ri));
        chk({tag, ".alu_op"},  32'(alu_op), 32'(a));
        chk({tag, ".halted"},  32'(halted), 32'(h));
        chk({tag, ".illegal"}, 32'(illegal), 32'(il));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear = 1'b0; run = 1'b0; ir = 32'h0; mem_ready = 1'b0;
        #2;
        check_all("reset", 4'd0, NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        #10;
        clear = 1'b1;

        // AND fetch/execute, zero wait states
        vecs.push_back(mk(1'b1, 1'b1, 32'h0,   4'd0, NONE, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0,   4'd1, C_T0, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0,   4'd2, C_T1, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_AND,  4'd4, C_T2, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_AND,  4'd5, YI,   16'h0004, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_AND,  4'd6, ZI,   16'h0008, 16'h0, 5'd5, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_AND,  4'd7, ZLOWO, 16'h0, 16'h0002, 5'd0, 1'b0));
        // three memory wait cycles
        vecs.push_back(mk(1'b0, 1'b0, IR_AND,  4'd1, C_T0, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, IR_AND,  4'd2, C_T1, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, IR_AND,  4'd3, C_TW, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, IR_AND,  4'd3, C_TW, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_AND,  4'd3, C_TW, 16'h0, 16'h0, 5'd0, 1'b0));
        // NOP
        vecs.push_back(mk(1'b0, 1'b1, IR_NOP,  4'd4, C_T2, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_NOP,  4'd5, NONE, 16'h0, 16'h0, 5'd0, 1'b0));
        // ADD R0,R0,R0
        vecs.push_back(mk(1'b0, 1'b1, IR_NOP,  4'd1, C_T0, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_NOP,  4'd2, C_T1, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_ADD0, 4'd4, C_T2, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_ADD0, 4'd5, YI,   16'h0001, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_ADD0, 4'd6, ZI,   16'h0001, 16'h0, 5'd3, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_ADD0, 4'd7, ZLOWO, 16'h0, 16'h0001, 5'd0, 1'b0));
        // unknown opcode reaches decode
        vecs.push_back(mk(1'b0, 1'b1, IR_ADD0, 4'd1, C_T0, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_ADD0, 4'd2, C_T1, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_UNK,  4'd4, C_T2, 16'h0, 16'h0, 5'd0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, IR_UNK,  4'd5, NONE, 16'h0, 16'h0, 5'd0, 1'b1));

        foreach (vecs[i]) begin
            run = vecs[i].run; mem_ready = vecs[i].mr; ir = vecs[i].ir;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].rout,
                      vecs[i].rin, vecs[i].alu, 1'b0, vecs[i].ill);
            step();
        end

`ifdef ILLEGAL_TRAP_EN
        run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check_all($sformatf("trap%0d", k), 4'd8, NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1);
            step();
        end
`else
        check_all("unk_after", 4'd1, C_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        step();
        check_all("halt_t1", 4'd2, C_T1, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        ir = IR_HALT;
        step();
        step();
        check_all("halt_t3", 4'd5, NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        run = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            check_all($sformatf("halt%0d", k), 4'd8, NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
            step();
        end
`endif

        // clear asserted in the middle of T4
        clear = 1'b0;
        #2;
        clear = 1'b1;
        run = 1'b1; mem_ready = 1'b1; ir = IR_AND;
        step();
        run = 1'b0;
        step(); step(); step(); step();
        check_all("pre_clr", 4'd6, ZI, 16'h0008, 16'h0, 5'd5, 1'b0, 1'b0);
        #2;
        clear = 1'b0;
        #1;
        check_all("mid_clr", 4'd0, NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        #1;
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_all($sformatf("idle%0d", k), 4'd0, NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
